// File: rtl/lsu_store_buffer_if.sv
// Store-buffer port bundle: LSU store requests, memory drain channel and
// the load-path forwarding lookup.
interface lsu_store_buffer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
);
    localparam int NB = DATA_W / 8;
    localparam int CW = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic [1:0]        in_size;
    logic [DATA_W-1:0] in_data;
    logic              in_err;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;
    logic [NB-1:0]     out_be;
    logic [ADDR_W-1:0] fwd_addr;
    logic [NB-1:0]     fwd_be;
    logic [DATA_W-1:0] fwd_data;
    logic [CW-1:0]     count;

    modport master (
        output in_valid, in_addr, in_size, in_data, out_ready, fwd_addr,
        input  in_ready, in_err, out_valid, out_addr, out_data, out_be,
               fwd_be, fwd_data, count
    );

    modport slave (
        input  in_valid, in_addr, in_size, in_data, out_ready, fwd_addr,
        output in_ready, in_err, out_valid, out_addr, out_data, out_be,
               fwd_be, fwd_data, count
    );
endinterface

// File: rtl/lsu_store_buffer.sv
// Byte-lane store buffer: aligns stores to lanes, merges into the youngest
// entry on a word match, drains in order and forwards to loads.
module lsu_store_buffer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input logic               clk,
    input logic               rst,
    lsu_store_buffer_if.slave sb
);
    localparam int NB   = DATA_W / 8;
    localparam int OFFW = $clog2(NB);
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;
    localparam int WW   = ADDR_W - OFFW;

    typedef struct packed {
        logic [WW-1:0]        word;
        logic [NB-1:0]        be;
        logic [NB-1:0][7:0]   data;
    } ent_t;

    ent_t            ent [DEPTH];
    logic [PW-1:0]   head, tail, yng, idx;
    logic [CW-1:0]   cnt;
    logic            err_q;

    logic [OFFW-1:0]    off;
    logic [3:0]         nbytes, bmask;
    logic [WW-1:0]      in_word, fwd_word;
    logic               illegal, pop, merge, ready, acc, push, do_merge, alloc;
    logic [NB-1:0]      mask, fbe;
    logic [NB-1:0][7:0] sdata, fdat;

    always_comb begin
        off     = sb.in_addr[OFFW-1:0];
        nbytes  = 4'd1 << sb.in_size;
        bmask   = nbytes - 4'd1;
        in_word = sb.in_addr[ADDR_W-1:OFFW];
        illegal = (DATA_W == 32 && sb.in_size == 2'd3) || ((off & bmask[OFFW-1:0]) != '0);
        mask    = '0;
        for (int i = 0; i < NB; i++)
            mask[i] = (i >= int'(off)) && (i < int'(off) + int'(nbytes));
        sdata   = sb.in_data << {off, 3'b000};
    end

    // A head that leaves this cycle cannot absorb a merge; the store allocates instead.
    assign yng      = tail - PW'(1);
    assign pop      = (cnt != '0) && sb.out_ready;
    assign merge    = (cnt != '0) && (ent[yng].word == in_word) && !(cnt == CW'(1) && pop);
    assign ready    = (cnt < CW'(DEPTH)) || merge;
    assign acc      = sb.in_valid && ready;
    assign push     = acc && !illegal;
    assign do_merge = push && merge;
    assign alloc    = push && !merge;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            cnt   <= '0;
            err_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
        end else begin
            err_q <= acc && illegal;
            if (pop) begin
                ent[head].be <= '0;
                head         <= head + PW'(1);
            end
            if (alloc) begin
                ent[tail].word <= in_word;
                ent[tail].be   <= mask;
                ent[tail].data <= sdata;
                tail           <= tail + PW'(1);
            end
            if (do_merge) begin
                ent[yng].be <= ent[yng].be | mask;
                for (int l = 0; l < NB; l++)
                    if (mask[l]) ent[yng].data[l] <= sdata[l];
            end
            cnt <= cnt + CW'(alloc) - CW'(pop);
        end
    end

    // Walk oldest to youngest so younger lanes overwrite older ones.
    assign fwd_word = sb.fwd_addr[ADDR_W-1:OFFW];
    always_comb begin
        fbe  = '0;
        fdat = '0;
        idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if (CW'(k) < cnt && ent[idx].word == fwd_word)
                for (int l = 0; l < NB; l++)
                    if (ent[idx].be[l]) begin
                        fbe[l]  = 1'b1;
                        fdat[l] = ent[idx].data[l];
                    end
        end
    end

    assign sb.in_ready  = ready;
    assign sb.in_err    = err_q;
    assign sb.out_valid = (cnt != '0);
    assign sb.out_addr  = (cnt != '0) ? {ent[head].word, {OFFW{1'b0}}} : '0;
    assign sb.out_data  = (cnt != '0) ? ent[head].data : '0;
    assign sb.out_be    = (cnt != '0) ? ent[head].be : '0;
    assign sb.fwd_be    = fbe;
    assign sb.fwd_data  = fdat;
    assign sb.count     = cnt;
endmodule
